// File: rtl/ibex_instr_mem_responder.sv
// Instruction-side memory responder.
// Acts as the target of the req/gnt/rvalid fetch bus. It backs a word-addressed
// RAM and answers every granted fetch, in order, after a fixed latency. The
// number of granted-but-unanswered requests is bounded. Misaligned and
// out-of-range fetches complete with an error and zero data.
module ibex_instr_mem_responder #(
    parameter int unsigned MEM_WORDS       = 256,
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int unsigned RESP_LATENCY    = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 instr_req_i,
    input  logic [31:0]                          instr_addr_i,
    output logic                                 instr_gnt_o,
    output logic                                 instr_rvalid_o,
    output logic [31:0]                          instr_rdata_o,
    output logic                                 instr_err_o,
    input  logic                                 stall_i,
    input  logic                                 load_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0]         load_addr_i,
    input  logic [31:0]                          load_wdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MaxOut = CW'(MAX_OUTSTANDING);
    localparam logic [32:0] MemBytes = 33'(MEM_WORDS) << 2;

    logic [31:0]             mem_q [MEM_WORDS];

    logic [RESP_LATENCY-1:0] pipeValid_q;
    logic [RESP_LATENCY-1:0] pipeErr_q;
    logic [31:0]             pipeData_q [RESP_LATENCY];

    logic [CW-1:0]           outstanding_q;
    logic [CW-1:0]           outstanding_d;

    logic                    grant;
    logic [31:0]             offset;
    logic                    decErr;
    logic [31:0]             decData;

    // A response leaving the pipeline this cycle frees its slot, so a new
    // request can be granted even when the counter sits at the limit.
    assign grant = instr_req_i & ~stall_i & ~rst_i &
                   ((outstanding_q < MaxOut) | instr_rvalid_o);

    assign instr_gnt_o = grant;

    // Decode the fetch address; the RAM word is read combinationally in the
    // grant cycle, so a load write on the same edge is not seen by this fetch.
    always_comb begin
        offset  = instr_addr_i - ADDR_BASE;
        decErr  = (instr_addr_i[1:0] != 2'b00) | ({1'b0, offset} >= MemBytes);
        decData = decErr ? 32'h0 : mem_q[offset[2 +: AW]];
    end

    // RAM load port; contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    // Fixed-latency response delay line; stage 0 captures the decoded grant so
    // later RAM writes cannot change a response that is already in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipeValid_q <= '0;
            pipeErr_q   <= '0;
            for (int i = 0; i < RESP_LATENCY; i++) begin
                pipeData_q[i] <= 32'h0;
            end
        end else begin
            pipeValid_q[0] <= grant;
            pipeErr_q[0]   <= grant & decErr;
            pipeData_q[0]  <= grant ? decData : 32'h0;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeErr_q[i]   <= pipeErr_q[i-1];
                pipeData_q[i]  <= pipeData_q[i-1];
            end
        end
    end

    // The last stage drives the bus; data and error read as zero when idle.
    assign instr_rvalid_o = pipeValid_q[RESP_LATENCY-1];
    assign instr_err_o    = pipeValid_q[RESP_LATENCY-1] & pipeErr_q[RESP_LATENCY-1];
    assign instr_rdata_o  = pipeValid_q[RESP_LATENCY-1] ? pipeData_q[RESP_LATENCY-1] : 32'h0;

    // In-flight count: up on grant, down on response, unchanged on both.
    always_comb begin
        outstanding_d = outstanding_q;
        if (grant && !instr_rvalid_o) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!grant && instr_rvalid_o) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    // Register the in-flight count; reset drops every pending response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding_o = outstanding_q;

    // A response can only appear while at least one request is in flight.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     instr_rvalid_o |-> (outstanding_q != '0));

    // The in-flight count never passes the configured limit.
    assert property (@(posedge clk_i) disable iff (rst_i)
                     outstanding_q <= MaxOut);

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder.
// A default instance (latency 2, two outstanding) is driven through directed
// fetch sequences and checked against a scoreboard of expected responses; a
// second instance (latency 1, one outstanding) checks back-to-back streaming.
module tb_ibex_instr_mem_responder;

    localparam int          Latency  = 2;
    localparam int          MaxOut   = 2;
    localparam logic [31:0] AddrBase = 32'h0000_0000;

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        loadWe;
    logic [7:0]  loadAddr;
    logic [31:0] loadWdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  outstanding;

    logic        req2;
    logic [31:0] addr2;
    logic        stall2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic        err2;
    logic [0:0]  outstanding2;

    resp_t       sb[$];
    logic [31:0] modelMem [256];
    int          cyc;
    int          compared;
    int          mismatched;
    logic        lastGnt;
    logic        prev2Valid;
    logic [31:0] prev2Data;

    ibex_instr_mem_responder #(
        .MEM_WORDS      (256),
        .ADDR_BASE      (AddrBase),
        .RESP_LATENCY   (Latency),
        .MAX_OUTSTANDING(MaxOut)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_req_i   (req),
        .instr_addr_i  (addr),
        .instr_gnt_o   (gnt),
        .instr_rvalid_o(rvalid),
        .instr_rdata_o (rdata),
        .instr_err_o   (err),
        .stall_i       (stall),
        .load_we_i     (loadWe),
        .load_addr_i   (loadAddr),
        .load_wdata_i  (loadWdata),
        .outstanding_o (outstanding)
    );

    ibex_instr_mem_responder #(
        .MEM_WORDS      (256),
        .ADDR_BASE      (AddrBase),
        .RESP_LATENCY   (1),
        .MAX_OUTSTANDING(1)
    ) dutFast (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_req_i   (req2),
        .instr_addr_i  (addr2),
        .instr_gnt_o   (gnt2),
        .instr_rvalid_o(rvalid2),
        .instr_rdata_o (rdata2),
        .instr_err_o   (err2),
        .stall_i       (stall2),
        .load_we_i     (loadWe),
        .load_addr_i   (loadAddr),
        .load_wdata_i  (loadWdata),
        .outstanding_o (outstanding2)
    );

    // Free-running clock shared by both instances.
    always #5 clk = ~clk;

    // One comparison: counted always, reported and counted as a failure on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive the fetch inputs of the default instance.
    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic s);
        req   = r;
        addr  = a;
        stall = s;
    endtask

    // One clock cycle: compare outputs mid-cycle against the scoreboards, then
    // advance the reference state for whatever the current inputs imply.
    task automatic step();
        resp_t       entry;
        logic        expRvalid;
        logic        expGnt;
        logic [31:0] expData;
        logic        expErr;
        logic [31:0] offset;
        logic        exp2Gnt;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            prev2Valid = 1'b0;
        end
        expRvalid = 1'b0;
        expData   = 32'h0;
        expErr    = 1'b0;
        if (sb.size() > 0) begin
            if (sb[0].due == cyc) begin
                expRvalid = 1'b1;
                expData   = sb[0].data;
                expErr    = sb[0].err;
            end
        end
        expGnt = req & ~stall & ~rst & ((sb.size() < MaxOut) || expRvalid);
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        checkOutput("rvalid", 32'(rvalid), 32'(expRvalid));
        checkOutput("rdata", rdata, expData);
        checkOutput("err", 32'(err), 32'(expErr));
        checkOutput("outstanding", 32'(outstanding), 32'(sb.size()));
        if (expRvalid) begin
            void'(sb.pop_front());
        end
        if (expGnt) begin
            offset     = addr - AddrBase;
            entry.due  = cyc + Latency;
            entry.err  = (addr[1:0] != 2'b00) || (offset >= 32'd1024);
            entry.data = entry.err ? 32'h0 : modelMem[offset[9:2]];
            sb.push_back(entry);
        end
        lastGnt = expGnt;

        exp2Gnt = req2 & ~rst;
        checkOutput("fastGnt", 32'(gnt2), 32'(exp2Gnt));
        checkOutput("fastRvalid", 32'(rvalid2), 32'(prev2Valid));
        checkOutput("fastRdata", rdata2, prev2Valid ? prev2Data : 32'h0);
        checkOutput("fastErr", 32'(err2), 32'h0);
        checkOutput("fastOutstanding", 32'(outstanding2), 32'(prev2Valid));
        prev2Valid = exp2Gnt;
        prev2Data  = modelMem[addr2[9:2]];

        if (loadWe) begin
            modelMem[loadAddr] = loadWdata;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Hold a request until the reference says it is granted, then drop it.
    task automatic fetch(input logic [31:0] a);
        int n;
        n = 0;
        applyStimulus(1'b1, a, 1'b0);
        do begin
            step();
            n++;
        end while (!lastGnt && n < 20);
        if (!lastGnt) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL fetchTimeout: addr %h not granted within %0d cycles", a, n);
        end
        applyStimulus(1'b0, a, 1'b0);
    endtask

    // Idle cycles to let in-flight responses drain.
    task automatic drain(input int n);
        repeat (n) step();
    endtask

    // Directed sequence covering reset, streaming, errors, stall, load
    // ordering, mid-flight reset and the single-slot fast configuration.
    initial begin
        rst = 1'b1; req = 1'b0; addr = 32'h0; stall = 1'b0;
        loadWe = 1'b0; loadAddr = 8'h0; loadWdata = 32'h0;
        req2 = 1'b0; addr2 = 32'h0; stall2 = 1'b0;
        cyc = 0; compared = 0; mismatched = 0; lastGnt = 1'b0;
        prev2Valid = 1'b0; prev2Data = 32'h0;
        for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;

        $display("[TB] reset");
        step();
        step();
        rst = 1'b0;
        step();

        $display("[TB] load RAM[0..3]");
        for (int i = 0; i < 4; i++) begin
            loadWe    = 1'b1;
            loadAddr  = 8'(i);
            loadWdata = 32'h1111_1111 * (i + 1);
            step();
        end
        loadWe = 1'b0;

        $display("[TB] streaming fetches");
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        fetch(32'hC);
        drain(4);

        $display("[TB] misaligned and out-of-range fetches");
        fetch(32'h0000_0402);
        fetch(32'h0000_0400);
        drain(4);

        $display("[TB] stall");
        applyStimulus(1'b1, 32'h8, 1'b1);
        repeat (5) step();
        fetch(32'h8);
        drain(4);

        $display("[TB] load after grant and in the grant cycle");
        fetch(32'h0);
        loadWe = 1'b1; loadAddr = 8'd0; loadWdata = 32'hDEAD_BEEF;
        step();
        loadWe = 1'b0;
        drain(3);
        fetch(32'h0);
        drain(3);
        loadWe = 1'b1; loadAddr = 8'd1; loadWdata = 32'h5555_5555;
        fetch(32'h4);
        loadWe = 1'b0;
        drain(3);
        fetch(32'h4);
        drain(3);

        $display("[TB] reset with requests in flight");
        fetch(32'h0);
        fetch(32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drain(4);
        fetch(32'h8);
        drain(4);

        $display("[TB] single-slot latency-1 streaming");
        for (int k = 0; k < 8; k++) begin
            req2  = 1'b1;
            addr2 = 32'((k % 4) * 4);
            step();
        end
        req2 = 1'b0;
        drain(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
